// File: rtl/exp_loader_if.sv
// Bundles the loader's stream input, RAM write port, exponent outputs and exponentiator handshake.
// master = the loader itself, slave = the environment that feeds it and consumes its outputs.
interface exp_loader_if #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 512,
    parameter int BITLEN     = 1024,
    parameter int LOG_BITLEN = 10,
    parameter int WBITS      = 32
);
    logic                  load_start;
    logic [ABITS-1:0]      load_words;
    logic                  in_valid;
    logic                  in_ready;
    logic [WBITS-1:0]      in_data;
    logic                  mem_wr_en;
    logic [ABITS-1:0]      mem_wr_addr;
    logic [DBITS-1:0]      mem_wr_data;
    logic [BITLEN-1:0]     e;
    logic [LOG_BITLEN-1:0] e_idx;
    logic                  exp_start;
    logic                  exp_stop;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  load_start, load_words, in_valid, in_data, exp_stop,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, e, e_idx,
               exp_start, busy, done, err
    );

    modport slave (
        output load_start, load_words, in_valid, in_data, exp_stop,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, e, e_idx,
               exp_start, busy, done, err
    );
endinterface

// File: rtl/exp_loader.sv
// Packs a 32-bit operand stream into RAM words, captures the exponent, finds its MSB, runs the exponentiator.
// RAM write lands one cycle after a word completes; in_ready is high only while loading, the stream stalls freely.
module exp_loader #(
    parameter int ABITS      = 8,
    parameter int DBITS      = 512,
    parameter int BITLEN     = 1024,
    parameter int LOG_BITLEN = 10,   // e_idx must cover 0..BITLEN-1
    parameter int WBITS      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    exp_loader_if.master bus
);
    localparam int NMEM = DBITS / WBITS;
    localparam int NEXP = BITLEN / WBITS;
    localparam int NMAX = (NEXP > NMEM) ? NEXP : NMEM;
    localparam int CW   = $clog2(NMAX) + 1;
    localparam int BW   = (WBITS > 1) ? $clog2(WBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_MEM, S_LOAD_EXP, S_SCAN, S_START, S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ABITS-1:0]      words_q, words_d;
    logic [ABITS-1:0]      wcnt_q, wcnt_d;
    logic [ABITS-1:0]      addr_q, addr_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic                  wr_en_q, wr_en_d;
    logic [DBITS-1:0]      shreg_q, shreg_d;
    logic [BITLEN-1:0]     e_q, e_d;
    logic [LOG_BITLEN-1:0] e_idx_q, e_idx_d;
    logic                  stop_q;

    logic                  ready;
    logic                  accept;
    logic                  stop_rise;
    logic                  start_pulse;
    logic                  done_pulse;
    logic                  err_pulse;
    logic [WBITS-1:0]      slice;
    logic                  hit;
    logic [BW-1:0]         bpos;
    logic [LOG_BITLEN-1:0] cand_idx;

    assign accept    = bus.in_valid & ready;
    assign stop_rise = bus.exp_stop & ~stop_q;

    // chunk_q doubles as the slice pointer while scanning downwards
    assign slice = e_q[32'(chunk_q) * WBITS +: WBITS];

    always_comb begin
        hit  = 1'b0;
        bpos = '0;
        for (int i = 0; i < WBITS; i++) begin
            if (slice[i]) begin
                hit  = 1'b1;
                bpos = i[BW-1:0];
            end
        end
        cand_idx = LOG_BITLEN'(chunk_q) * LOG_BITLEN'(WBITS) + LOG_BITLEN'(bpos);
    end

    always_comb begin
        state_d     = state_q;
        words_d     = words_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        chunk_d     = chunk_q;
        wr_en_d     = 1'b0;
        shreg_d     = shreg_q;
        e_d         = e_q;
        e_idx_d     = e_idx_q;
        ready       = 1'b0;
        start_pulse = 1'b0;
        done_pulse  = 1'b0;
        err_pulse   = 1'b0;

        // the write of the final RAM word may overlap the first exponent cycle
        if (wr_en_q) begin
            addr_d = addr_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    words_d = bus.load_words;
                    wcnt_d  = '0;
                    addr_d  = '0;
                    chunk_d = '0;
                    e_d     = '0;
                    state_d = (bus.load_words == '0) ? S_LOAD_EXP : S_LOAD_MEM;
                end
            end
            S_LOAD_MEM: begin
                ready = 1'b1;
                if (accept) begin
                    shreg_d = {bus.in_data, shreg_q[DBITS-1:WBITS]};
                    if (chunk_q == CW'(NMEM - 1)) begin
                        chunk_d = '0;
                        wr_en_d = 1'b1;
                        wcnt_d  = wcnt_q + 1'b1;
                        if (wcnt_q + 1'b1 == words_q) begin
                            state_d = S_LOAD_EXP;
                        end
                    end else begin
                        chunk_d = chunk_q + 1'b1;
                    end
                end
            end
            S_LOAD_EXP: begin
                ready = 1'b1;
                if (accept) begin
                    e_d = {bus.in_data, e_q[BITLEN-1:WBITS]};
                    if (chunk_q == CW'(NEXP - 1)) begin
                        state_d = S_SCAN;
                    end else begin
                        chunk_d = chunk_q + 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (hit) begin
                    if (cand_idx == '0) begin
                        err_pulse = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        e_idx_d = cand_idx;
                        state_d = S_START;
                    end
                end else if (chunk_q == '0) begin
                    err_pulse = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    chunk_d = chunk_q - 1'b1;
                end
            end
            S_START: begin
                start_pulse = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (stop_rise) begin
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            words_q <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            chunk_q <= '0;
            wr_en_q <= 1'b0;
            shreg_q <= '0;
            e_q     <= '0;
            e_idx_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            chunk_q <= chunk_d;
            wr_en_q <= wr_en_d;
            shreg_q <= shreg_d;
            e_q     <= e_d;
            e_idx_q <= e_idx_d;
            stop_q  <= bus.exp_stop;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = shreg_q;
    assign bus.e           = e_q;
    assign bus.e_idx       = e_idx_q;
    assign bus.exp_start   = start_pulse;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_pulse;
    assign bus.err         = err_pulse;
endmodule

// File: tb/tb_exp_loader.sv
// Randomized scoreboard bench for exp_loader: a driver pushes expected RAM writes and outcomes,
// a negedge monitor pops and compares whenever the loader writes, starts, or flags an error.
module tb_exp_loader;
    localparam int ABITS      = 8;
    localparam int DBITS      = 512;
    localparam int BITLEN     = 1024;
    localparam int LOG_BITLEN = 10;
    localparam int WBITS      = 32;
    localparam int NMEM       = DBITS / WBITS;
    localparam int NEXP       = BITLEN / WBITS;

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [DBITS-1:0] data;
    } wr_t;

    typedef struct {
        bit                is_err;
        bit                chk_idx;
        logic [BITLEN-1:0] e;
        int                idx;
        int                scan;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    exp_loader_if #(.ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN),
                    .LOG_BITLEN(LOG_BITLEN), .WBITS(WBITS)) bus ();

    exp_loader #(.ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN),
                 .LOG_BITLEN(LOG_BITLEN), .WBITS(WBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    wr_t  wr_q[$];
    res_t res_q[$];
    bit   scanning      = 1'b0;
    bit   chk_busy_next = 1'b0;
    bit   done_expect   = 1'b0;
    int   scan_cnt      = 0;
    int   mdl_idx       = 0;
    wr_t  mw;
    res_t mr;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [BITLEN-1:0] act, input logic [BITLEN-1:0] exp);
        int j;
        j = -1;
        for (int i = NEXP - 1; i >= 0; i--)
            if (act[i*WBITS +: WBITS] !== exp[i*WBITS +: WBITS]) j = i;
        checks++;
        if (j >= 0) begin
            errors++;
            $display("FAIL %s slice %0d: got %h expected %h", name, j,
                     act[j*WBITS +: WBITS], exp[j*WBITS +: WBITS]);
        end
    endtask

    // Reference: highest set bit by plain bit search; e<2 is an error
    function automatic res_t model(input logic [BITLEN-1:0] ev);
        res_t r;
        int   top;
        top = -1;
        for (int i = 0; i < BITLEN; i++) if (ev[i]) top = i;
        r.e       = ev;
        r.is_err  = (top < 1);
        r.chk_idx = (top < 0);
        r.idx     = (top < 1) ? mdl_idx : top;
        r.scan    = (top < 0) ? NEXP : NEXP - top / WBITS;
        return r;
    endfunction

    function automatic logic [BITLEN-1:0] rand_e();
        logic [BITLEN-1:0] v;
        int z;
        z = $urandom_range(0, NEXP - 1);
        for (int j = 0; j < NEXP; j++)
            v[j*WBITS +: WBITS] = (j >= NEXP - z) ? '0 : WBITS'($urandom);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_busy_next) begin
                check(bus.busy == 1'b0, "busy_after_err", bus.busy, 0);
                chk_busy_next = 1'b0;
            end
            if (bus.mem_wr_en) begin
                if (wr_q.size() == 0) check(1'b0, "unexpected_write", bus.mem_wr_addr, 0);
                else begin
                    mw = wr_q.pop_front();
                    check(bus.mem_wr_addr == mw.addr, "wr_addr", bus.mem_wr_addr, mw.addr);
                    check_wide("wr_data", BITLEN'(bus.mem_wr_data), BITLEN'(mw.data));
                end
            end
            if (bus.exp_start || bus.err) begin
                if (!scanning || res_q.size() == 0)
                    check(1'b0, "unexpected_start_or_err", {bus.exp_start, bus.err}, 0);
                else begin
                    mr = res_q.pop_front();
                    if (bus.err) scan_cnt++;
                    check(bus.err == mr.is_err, "outcome_err", bus.err, mr.is_err);
                    check(scan_cnt == mr.scan, "scan_cycles", scan_cnt, mr.scan);
                    if (!mr.is_err) begin
                        check_wide("e_at_start", bus.e, mr.e);
                        check(bus.e_idx == LOG_BITLEN'(mr.idx), "e_idx", bus.e_idx, mr.idx);
                    end else if (mr.chk_idx) begin
                        check(bus.e_idx == LOG_BITLEN'(mr.idx), "e_idx_hold", bus.e_idx, mr.idx);
                    end
                    if (bus.err) chk_busy_next = 1'b1;
                end
                scanning = 1'b0;
            end else if (scanning && !bus.in_ready) begin
                scan_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                scanning = 1'b1;
                scan_cnt = 0;
            end
            if (bus.done && !done_expect) check(1'b0, "unexpected_done", 1, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WBITS-1:0] w, input int gap_pct, output bit ok);
        bit acc;
        ok = 1'b0;
        if (int'($urandom_range(0, 99)) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = WBITS'($urandom);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(1'b0, "stream_timeout", 0, 1);
    endtask

    task automatic do_reset_checks();
        check(bus.in_ready == 1'b0,  "rst_in_ready",  bus.in_ready, 0);
        check(bus.mem_wr_en == 1'b0, "rst_mem_wr_en", bus.mem_wr_en, 0);
        check(bus.exp_start == 1'b0, "rst_exp_start", bus.exp_start, 0);
        check(bus.busy == 1'b0,      "rst_busy",      bus.busy, 0);
        check({bus.done, bus.err} == 2'b00, "rst_done_err", {bus.done, bus.err}, 0);
        check(bus.mem_wr_addr == '0, "rst_addr",      bus.mem_wr_addr, 0);
        check(bus.e_idx == '0,       "rst_e_idx",     bus.e_idx, 0);
        check_wide("rst_wr_data", BITLEN'(bus.mem_wr_data), '0);
        check_wide("rst_e", bus.e, '0);
    endtask

    task automatic run(input int lw, input logic [BITLEN-1:0] ev, input bit inc_data,
                       input int gap_pct, input bit keep_stop, input int abort_after);
        logic [WBITS-1:0] words[$];
        res_t r;
        wr_t  w;
        bit   ok;
        int   acc;
        int   n;
        acc = 0;
        for (int k = 0; k < lw * NMEM; k++)
            words.push_back(inc_data ? WBITS'(k) : WBITS'($urandom));
        for (int j = 0; j < NEXP; j++) words.push_back(ev[j*WBITS +: WBITS]);
        r = model(ev);
        if (abort_after < 0) begin
            for (int k = 0; k < lw; k++) begin
                w.addr = ABITS'(k);
                for (int j = 0; j < NMEM; j++) w.data[j*WBITS +: WBITS] = words[k*NMEM + j];
                wr_q.push_back(w);
            end
            res_q.push_back(r);
        end
        if (!keep_stop) bus.exp_stop = 1'b0;
        bus.load_start = 1'b1;
        bus.load_words = ABITS'(lw);
        tick();
        bus.load_start = 1'b0;
        bus.load_words = ABITS'($urandom);
        for (int i = 0; i < words.size(); i++) begin
            send_word(words[i], gap_pct, ok);
            if (!ok) break;
            acc++;
            if (acc == abort_after) break;
        end
        bus.in_valid = 1'b0;
        if (!ok || abort_after >= 0) begin
            if (abort_after >= 0) begin
                rst_n = 1'b0;
                #2;
                do_reset_checks();
            end
            wr_q.delete();
            res_q.delete();
            scanning      = 1'b0;
            chk_busy_next = 1'b0;
            mdl_idx       = 0;
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            return;
        end
        if (r.is_err) begin
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (!bus.busy) break;
            end
            check(n < 200, "err_timeout", n, 200);
        end else begin
            for (n = 0; n < 200; n++) begin
                @(negedge clk);
                if (bus.exp_start) break;
            end
            check(n < 200, "start_timeout", n, 200);
            tick();
            bus.load_start = 1'b1;
            bus.load_words = 8'd1;
            tick();
            bus.load_start = 1'b0;
            if (bus.exp_stop) begin
                repeat (4) tick();
                bus.exp_stop = 1'b0;
                repeat (2) tick();
            end else begin
                repeat ($urandom_range(0, 5)) tick();
            end
            bus.exp_stop = 1'b1;
            done_expect  = 1'b1;
            @(negedge clk);
            check(bus.done == 1'b1, "done_on_edge", bus.done, 1);
            check_wide("e_hold", bus.e, ev);
            check(bus.e_idx == LOG_BITLEN'(r.idx), "e_idx_hold_wait", bus.e_idx, r.idx);
            tick();
            done_expect = 1'b0;
            @(negedge clk);
            check({bus.busy, bus.done} == 2'b00, "idle_after_done", {bus.busy, bus.done}, 0);
            mdl_idx = r.idx;
        end
        tick();
        check(wr_q.size() == 0, "writes_missing", wr_q.size(), 0);
        check(res_q.size() == 0, "outcome_missing", res_q.size(), 0);
    endtask

    initial begin
        logic [BITLEN-1:0] ev;
        bus.load_start = 1'b0;
        bus.load_words = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.exp_stop   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        do_reset_checks();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        ev = '0; ev[0] = 1'b1; ev[16] = 1'b1;
        run(2, ev, 1'b1, 0, 1'b0, -1);
        ev = '0; ev[1000] = 1'b1;
        run(0, ev, 1'b0, 0, 1'b0, -1);
        ev = '0;
        run(0, ev, 1'b0, 0, 1'b0, -1);
        ev = '0; ev[0] = 1'b1;
        run(1, ev, 1'b0, 20, 1'b0, -1);
        run(3, rand_e(), 1'b0, 50, 1'b0, -1);
        ev = rand_e(); ev[BITLEN-1] = 1'b1;
        run(1, ev, 1'b0, 30, 1'b1, -1);
        run(2, rand_e(), 1'b0, 0, 1'b0, 7);
        ev = '0; ev[1] = 1'b1;
        run(1, ev, 1'b0, 0, 1'b0, -1);
        for (int t = 0; t < 6; t++)
            run(int'($urandom_range(0, 3)), rand_e(), 1'b0, int'($urandom_range(0, 60)),
                1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
